verify_tracker: RTL and testbench

// - Downstream consumer of the verify stage: qualifies its registered enc_match/hash_match/valid_flag

---
 rtl/verify_tracker_if.sv | 53 +++++
 rtl/verify_tracker.sv | 217 +++++++++++++++++++++
 tb/tb_verify_tracker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/verify_tracker_if.sv
// ---------------------------------------------------------------------------
// verify_tracker_if
//   Bundles the sample handshake, the verify-stage flags, the clear strobe
//   and the statistics/status outputs of verify_tracker.
//
//   master : sample source / control side (drives samples, flags, clr)
//   slave  : the tracker itself (drives in_ready, result strobe, counters,
//            streak, state, locked and, with VERIFY_TRK_TAG_EN defined,
//            last_fail_tag)
//
//   Optional feature macro: VERIFY_TRK_TAG_EN adds last_fail_tag.
// ---------------------------------------------------------------------------
interface verify_tracker_if #(
  parameter int CNT_W    = 16,
  parameter int STREAK_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          sample_tag;
  logic                enc_match;
  logic                hash_match;
  logic                valid_flag;
  logic                clr;
  logic                result_valid;
  logic [CNT_W-1:0]    total_cnt;
  logic [CNT_W-1:0]    pass_cnt;
  logic [CNT_W-1:0]    enc_fail_cnt;
  logic [CNT_W-1:0]    hash_fail_cnt;
  logic [STREAK_W-1:0] streak;
  logic [1:0]          state;
  logic                locked;
`ifdef VERIFY_TRK_TAG_EN
  logic [7:0]          last_fail_tag;
`endif

  modport master (
`ifdef VERIFY_TRK_TAG_EN
    input  last_fail_tag,
`endif
    output in_valid, sample_tag, enc_match, hash_match, valid_flag, clr,
    input  in_ready, result_valid, total_cnt, pass_cnt, enc_fail_cnt,
           hash_fail_cnt, streak, state, locked
  );

  modport slave (
`ifdef VERIFY_TRK_TAG_EN
    output last_fail_tag,
`endif
    input  in_valid, sample_tag, enc_match, hash_match, valid_flag, clr,
    output in_ready, result_valid, total_cnt, pass_cnt, enc_fail_cnt,
           hash_fail_cnt, streak, state, locked
  );
endinterface

// File: rtl/verify_tracker.sv
// ---------------------------------------------------------------------------
// verify_tracker
//   Consumes the registered enc_match/hash_match/valid_flag of the verify
//   stage. Each accepted sample (in_valid & in_ready) is tracked through a
//   LATENCY-deep strobe pipe; when it emerges the flags present that cycle
//   belong to it and are recorded into saturating statistics counters.
//   A consecutive-fail streak drives an OK -> WARN -> LOCKED state machine;
//   LOCKED drops in_ready so no new samples are accepted until clr.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     trk    : verify_tracker_if.slave (samples, flags, clr, statistics)
//
//   Optional feature macro: VERIFY_TRK_TAG_EN carries sample_tag through
//   the pipe and reports the tag of the latest failing result on
//   last_fail_tag. Without it sample_tag is ignored.
// ---------------------------------------------------------------------------
module verify_tracker #(
  parameter int LATENCY  = 2,
  parameter int CNT_W    = 16,
  parameter int STREAK_W = 4,
  parameter int WARN_TH  = 2,
  parameter int LOCK_TH  = 4
) (
  input logic              clk,
  input logic              rst_n,
  verify_tracker_if.slave  trk
);

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_WARN   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_BAD    = 2'b11
  } state_e;

  localparam logic [STREAK_W-1:0] WARN_S = STREAK_W'(WARN_TH);
  localparam logic [STREAK_W-1:0] LOCK_S = STREAK_W'(LOCK_TH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    enc_fail_q, enc_fail_d;
  logic [CNT_W-1:0]    hash_fail_q, hash_fail_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rv_q, rv_d;

  logic                in_ready;
  logic                accept;
  logic                q_valid;
  logic                vpipe_q [LATENCY];

  assign in_ready = (state_q != ST_LOCKED);
  assign accept   = trk.in_valid & in_ready;
  assign q_valid  = vpipe_q[LATENCY-1];

`ifdef VERIFY_TRK_TAG_EN
  logic [7:0] tpipe_q [LATENCY];
  logic [7:0] last_tag_q, last_tag_d;
`else
  // sample_tag has no use without the tag feature.
  logic unused_tag_bits;
  assign unused_tag_bits = ^trk.sample_tag;
`endif

  // Strobe (and optional tag) alignment pipe. clr empties it so samples
  // accepted before the clear never reach the fresh statistics.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe_q[gi] <= 1'b0;
        end else begin
          vpipe_q[gi] <= trk.clr ? 1'b0 : accept;
        end
      end
`ifdef VERIFY_TRK_TAG_EN
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tpipe_q[gi] <= 8'h00;
        end else begin
          tpipe_q[gi] <= trk.sample_tag;
        end
      end
`endif
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vpipe_q[gi] <= 1'b0;
        end else begin
          vpipe_q[gi] <= trk.clr ? 1'b0 : vpipe_q[gi-1];
        end
      end
`ifdef VERIFY_TRK_TAG_EN
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tpipe_q[gi] <= 8'h00;
        end else begin
          tpipe_q[gi] <= tpipe_q[gi-1];
        end
      end
`endif
    end
  end

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [STREAK_W-1:0] inc_streak(input logic [STREAK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-state / statistics update. clr wins over everything, including a
  // result emerging from the pipe in the same cycle.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    pass_d      = pass_q;
    enc_fail_d  = enc_fail_q;
    hash_fail_d = hash_fail_q;
    streak_d    = streak_q;
    rv_d        = 1'b0;
`ifdef VERIFY_TRK_TAG_EN
    last_tag_d  = last_tag_q;
`endif
    if (trk.clr) begin
      state_d     = ST_OK;
      total_d     = '0;
      pass_d      = '0;
      enc_fail_d  = '0;
      hash_fail_d = '0;
      streak_d    = '0;
`ifdef VERIFY_TRK_TAG_EN
      last_tag_d  = 8'h00;
`endif
    end else begin
      if (state_q == ST_BAD) begin
        state_d = ST_OK;
      end
      if (q_valid) begin
        rv_d    = 1'b1;
        total_d = inc_cnt(total_q);
        if (trk.valid_flag) begin
          pass_d   = inc_cnt(pass_q);
          streak_d = '0;
          // A pass in LOCKED still clears the streak but keeps the lock.
          if (state_q == ST_WARN) begin
            state_d = ST_OK;
          end
        end else begin
          streak_d = inc_streak(streak_q);
`ifdef VERIFY_TRK_TAG_EN
          last_tag_d = tpipe_q[LATENCY-1];
`endif
          // LOCK is tested first so it wins when both thresholds are met.
          if (state_q != ST_LOCKED) begin
            if (streak_d >= LOCK_S) begin
              state_d = ST_LOCKED;
            end else if (streak_d >= WARN_S) begin
              state_d = ST_WARN;
            end
          end
        end
        if (!trk.enc_match) begin
          enc_fail_d = inc_cnt(enc_fail_q);
        end
        if (!trk.hash_match) begin
          hash_fail_d = inc_cnt(hash_fail_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OK;
      total_q     <= '0;
      pass_q      <= '0;
      enc_fail_q  <= '0;
      hash_fail_q <= '0;
      streak_q    <= '0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      pass_q      <= pass_d;
      enc_fail_q  <= enc_fail_d;
      hash_fail_q <= hash_fail_d;
      streak_q    <= streak_d;
      rv_q        <= rv_d;
    end
  end

`ifdef VERIFY_TRK_TAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tag_q <= 8'h00;
    end else begin
      last_tag_q <= last_tag_d;
    end
  end
  assign trk.last_fail_tag = last_tag_q;
`endif

  assign trk.in_ready      = in_ready;
  assign trk.result_valid  = rv_q;
  assign trk.total_cnt     = total_q;
  assign trk.pass_cnt      = pass_q;
  assign trk.enc_fail_cnt  = enc_fail_q;
  assign trk.hash_fail_cnt = hash_fail_q;
  assign trk.streak        = streak_q;
  assign trk.state         = state_q;
  assign trk.locked        = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_verify_tracker.sv
// ---------------------------------------------------------------------------
// tb_verify_tracker
//   Directed scenarios followed by randomized traffic. A reference model
//   keeps in-flight samples as a queue of (due cycle, tag) entries and
//   applies the recording rules with plain integer arithmetic; every DUT
//   output is compared with it once per cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_verify_tracker;

  localparam int LATENCY  = 2;
  localparam int CNT_W    = 4;
  localparam int STREAK_W = 4;
  localparam int WARN_TH  = 2;
  localparam int LOCK_TH  = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int STK_MAX  = (1 << STREAK_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  verify_tracker_if #(.CNT_W(CNT_W), .STREAK_W(STREAK_W)) bus ();

  verify_tracker #(
    .LATENCY(LATENCY), .CNT_W(CNT_W), .STREAK_W(STREAK_W),
    .WARN_TH(WARN_TH), .LOCK_TH(LOCK_TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trk   (bus)
  );

  // stimulus drivers
  logic       drv_iv  = 1'b0;
  logic       drv_vf  = 1'b1;
  logic       drv_em  = 1'b1;
  logic       drv_hm  = 1'b1;
  logic       drv_clr = 1'b0;
  logic [7:0] drv_tag = 8'h00;

  assign bus.in_valid   = drv_iv;
  assign bus.valid_flag = drv_vf;
  assign bus.enc_match  = drv_em;
  assign bus.hash_match = drv_hm;
  assign bus.clr        = drv_clr;
  assign bus.sample_tag = drv_tag;

  // reference model
  typedef struct {
    int         due;
    logic [7:0] tag;
  } pend_t;

  pend_t pq[$];
  int    cyc;
  int    m_total, m_pass, m_enc, m_hash, m_streak, m_state, m_rv;
  int    m_tag;
  int    rv_seen;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    pq.delete();
    m_total = 0; m_pass = 0; m_enc = 0; m_hash = 0;
    m_streak = 0; m_state = 0; m_rv = 0; m_tag = 0;
  endtask

  // Applies the inputs present during cycle 'cyc' (sampled at this edge).
  task automatic model_update();
    bit    acc;
    pend_t p;
    m_rv = 0;
    if (drv_clr) begin
      model_reset();
    end else begin
      acc = drv_iv && (m_state != 2);
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        m_rv = 1;
        m_total = sat(m_total, CNT_MAX);
        if (drv_vf) begin
          m_pass = sat(m_pass, CNT_MAX);
          m_streak = 0;
          if (m_state == 1) m_state = 0;
        end else begin
          m_streak = sat(m_streak, STK_MAX);
          m_tag = p.tag;
          if (m_state != 2) begin
            if (m_streak >= LOCK_TH) m_state = 2;
            else if (m_streak >= WARN_TH) m_state = 1;
          end
        end
        if (!drv_em) m_enc = sat(m_enc, CNT_MAX);
        if (!drv_hm) m_hash = sat(m_hash, CNT_MAX);
        $display("txn cyc=%0d tag=%02h vf=%0b em=%0b hm=%0b -> total=%0d pass=%0d streak=%0d state=%0d",
                 cyc, p.tag, drv_vf, drv_em, drv_hm, m_total, m_pass, m_streak, m_state);
      end
      if (acc) pq.push_back('{due: cyc + LATENCY, tag: drv_tag});
    end
    cyc++;
  endtask

  task automatic check_all();
    check("result_valid", 32'(bus.result_valid), 32'(m_rv));
    check("total_cnt",    32'(bus.total_cnt),    32'(m_total));
    check("pass_cnt",     32'(bus.pass_cnt),     32'(m_pass));
    check("enc_fail_cnt", 32'(bus.enc_fail_cnt), 32'(m_enc));
    check("hash_fail_cnt",32'(bus.hash_fail_cnt),32'(m_hash));
    check("streak",       32'(bus.streak),       32'(m_streak));
    check("state",        32'(bus.state),        32'(m_state));
    check("locked",       32'(bus.locked),       32'(m_state == 2));
    check("in_ready",     32'(bus.in_ready),     32'(m_state != 2));
`ifdef VERIFY_TRK_TAG_EN
    check("last_fail_tag",32'(bus.last_fail_tag),32'(m_tag));
`endif
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // where the caller then drives the next cycle's inputs.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (bus.result_valid === 1'b1) rv_seen++;
      check_all();
    end
  endtask

  task automatic set_flags(input logic vf, input logic em, input logic hm);
    drv_vf = vf; drv_em = em; drv_hm = hm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drv_iv = 1'b0; drv_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n, input int p_valid, input int p_fail, input int p_clr);
    for (int i = 0; i < n; i++) begin
      drv_iv  = ($urandom_range(99) < p_valid);
      drv_vf  = !($urandom_range(99) < p_fail);
      drv_em  = ($urandom_range(3) != 0);
      drv_hm  = ($urandom_range(3) != 0);
      drv_clr = ($urandom_range(99) < p_clr);
      drv_tag = 8'($urandom);
      tick();
    end
    drv_clr = 1'b0;
  endtask

  initial begin
    cyc = 0;
    rv_seen = 0;
    model_reset();
    do_reset();
    check("rst_total", 32'(bus.total_cnt), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // five passing samples back to back
    set_flags(1'b1, 1'b1, 1'b1);
    drv_iv = 1'b1; tick(5);
    drv_iv = 1'b0; tick(LATENCY + 1);
    check("dirA_strobes", 32'(rv_seen), 32'd5);
    check("dirA_total",   32'(bus.total_cnt), 32'd5);
    check("dirA_pass",    32'(bus.pass_cnt), 32'd5);
    check("dirA_state",   32'(bus.state), 32'd0);

    // two fails reach WARN, one pass returns to OK
    set_flags(1'b0, 1'b1, 1'b0);
    drv_iv = 1'b1; tick(2);
    drv_iv = 1'b0; tick(LATENCY + 1);
    check("dirB_streak", 32'(bus.streak), 32'd2);
    check("dirB_state",  32'(bus.state), 32'd1);
    check("dirB_hash",   32'(bus.hash_fail_cnt), 32'd2);
    check("dirB_enc",    32'(bus.enc_fail_cnt), 32'd0);
    set_flags(1'b1, 1'b1, 1'b1);
    drv_iv = 1'b1; tick(1);
    drv_iv = 1'b0; tick(LATENCY + 1);
    check("dirB_pass_streak", 32'(bus.streak), 32'd0);
    check("dirB_pass_state",  32'(bus.state), 32'd0);

    // clear, then back-to-back fails: lock with two more draining
    drv_clr = 1'b1; tick(1); drv_clr = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0);
    drv_iv = 1'b1; tick(12);
    drv_iv = 1'b0;
    check("dirC_total",  32'(bus.total_cnt), 32'd6);
    check("dirC_locked", 32'(bus.locked), 32'd1);
    check("dirC_ready",  32'(bus.in_ready), 32'd0);
    drv_clr = 1'b1; tick(1); drv_clr = 1'b0;
    check("dirC_clr_total", 32'(bus.total_cnt), 32'd0);
    check("dirC_clr_ready", 32'(bus.in_ready), 32'd1);

    // clr lands on the same cycle as a result
    set_flags(1'b1, 1'b1, 1'b1);
    drv_iv = 1'b1; tick(1);
    drv_iv = 1'b0; tick(LATENCY - 1);
    drv_clr = 1'b1; tick(1); drv_clr = 1'b0;
    check("dirD_rv", 32'(bus.result_valid), 32'd0);
    tick(LATENCY + 1);
    check("dirD_total", 32'(bus.total_cnt), 32'd0);

    // saturation
    drv_iv = 1'b1; tick(20);
    drv_iv = 1'b0; tick(LATENCY + 1);
    check("dirE_pass",  32'(bus.pass_cnt), 32'(CNT_MAX));
    check("dirE_total", 32'(bus.total_cnt), 32'(CNT_MAX));

`ifdef VERIFY_TRK_TAG_EN
    set_flags(1'b0, 1'b1, 1'b1);
    drv_tag = 8'hA5; drv_iv = 1'b1; tick(1);
    drv_tag = 8'h00; drv_iv = 1'b0; tick(LATENCY + 1);
    check("dirE_tag", 32'(bus.last_fail_tag), 32'hA5);
`endif

    // randomized traffic, a mid-stream reset, more traffic
    run_random(400, 60, 35, 3);
    drv_iv = 1'b1; tick(1);
    do_reset();
    check("mid_rst_total", 32'(bus.total_cnt), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    run_random(400, 80, 20, 2);
    run_random(300, 50, 60, 4);
    drv_iv = 1'b0; tick(LATENCY + 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
